ucsbece154b_perf_counters: RTL and testbench

//  Branch/jump prediction performance monitor fed by the Execute-stage control signals of the

---
 rtl/ucsbece154b_perf_pkg.sv | 23 ++
 rtl/ucsbece154b_sat_counter.sv | 30 +++
 rtl/ucsbece154b_perf_counters.sv | 118 +++++++++++
 tb/tb_ucsbece154b_perf_counters.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154b_perf_pkg.sv
// Shared types and constants for the branch/jump prediction performance monitor.
package ucsbece154b_perf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int NUM_CNT = 6;

  localparam logic [2:0] SEL_CYCLES    = 3'd0;
  localparam logic [2:0] SEL_BR_TOTAL  = 3'd1;
  localparam logic [2:0] SEL_BR_MISS   = 3'd2;
  localparam logic [2:0] SEL_JMP_TOTAL = 3'd3;
  localparam logic [2:0] SEL_JMP_MISS  = 3'd4;
  localparam logic [2:0] SEL_BR_TAKEN  = 3'd5;
  localparam logic [2:0] SEL_STATUS    = 3'd6;
  localparam logic [2:0] SEL_ID        = 3'd7;

  localparam logic [31:0] PERF_ID = 32'h5045_0001;

endpackage

// File: rtl/ucsbece154b_sat_counter.sv
// Saturating up-counter; sat_o flags an increment attempted while already at all-ones.
module ucsbece154b_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);

  logic [CNT_W-1:0] cnt_reg;
  logic             at_max;

  assign at_max = &cnt_reg;
  assign sat_o  = inc_i && at_max;
  assign cnt_o  = cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clr_i) begin
      cnt_reg <= '0;
    end else if (inc_i && !at_max) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ucsbece154b_perf_counters.sv
// Execute-stage branch/jump prediction monitor: run/halt FSM, event decode,
// six saturating counters and a registered readout port.
module ucsbece154b_perf_counters
  import ucsbece154b_perf_pkg::*;
#(
  parameter logic [31:0] HALT_PC = 32'h0001_0064,
  parameter int          CNT_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        clear_i,
  input  logic        validE_i,
  input  logic        BranchE_i,
  input  logic        JumpE_i,
  input  logic        PCSrcE_i,
  input  logic        BranchTakenE_i,
  input  logic [31:0] PCF_i,
  input  logic [2:0]  sel_i,
  output logic [31:0] data_o,
  output logic        halted_o,
  output logic        ovf_o
);

  state_t state_reg, state_next;

  logic               at_halt;
  logic               active;
  logic               is_br;
  logic               is_jmp;
  logic [NUM_CNT-1:0] inc;
  logic [NUM_CNT-1:0] sat;
  logic [CNT_W-1:0]   cnt     [NUM_CNT];
  logic [31:0]        cnt_ext [NUM_CNT];
  logic               ovf_reg;
  logic [31:0]        data_reg, data_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (clear_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (start_i) state_next = RUN;
        RUN:     if (at_halt) state_next = HALTED;
        HALTED:  state_next = HALTED;
        default: state_next = IDLE;
      endcase
    end
  end

  assign at_halt = (PCF_i == HALT_PC);
  // The cycle that reaches the halt PC is deliberately excluded from every counter.
  assign active  = (state_reg == RUN) && start_i && !at_halt;
  // An instruction flagged as both branch and jump is treated as a jump only.
  assign is_jmp  = validE_i && JumpE_i;
  assign is_br   = validE_i && BranchE_i && !JumpE_i;

  always_comb begin
    inc               = '0;
    inc[SEL_CYCLES]    = active;
    inc[SEL_BR_TOTAL]  = active && is_br;
    inc[SEL_BR_MISS]   = active && is_br && (PCSrcE_i != BranchTakenE_i);
    inc[SEL_JMP_TOTAL] = active && is_jmp;
    inc[SEL_JMP_MISS]  = active && is_jmp && !BranchTakenE_i;
    inc[SEL_BR_TAKEN]  = active && is_br && PCSrcE_i;
  end

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      ucsbece154b_sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (inc[gi]),
        .clr_i (clear_i),
        .cnt_o (cnt[gi]),
        .sat_o (sat[gi])
      );
      assign cnt_ext[gi] = 32'(cnt[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      ovf_reg <= 1'b0;
    else if (clear_i) ovf_reg <= 1'b0;
    else if (|sat)    ovf_reg <= 1'b1;
  end

  always_comb begin
    data_next = '0;
    case (sel_i)
      SEL_CYCLES:    data_next = cnt_ext[SEL_CYCLES];
      SEL_BR_TOTAL:  data_next = cnt_ext[SEL_BR_TOTAL];
      SEL_BR_MISS:   data_next = cnt_ext[SEL_BR_MISS];
      SEL_JMP_TOTAL: data_next = cnt_ext[SEL_JMP_TOTAL];
      SEL_JMP_MISS:  data_next = cnt_ext[SEL_JMP_MISS];
      SEL_BR_TAKEN:  data_next = cnt_ext[SEL_BR_TAKEN];
      SEL_STATUS:    data_next = {30'b0, ovf_reg, (state_reg == HALTED)};
      SEL_ID:        data_next = PERF_ID;
      default:       data_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) data_reg <= '0;
    else        data_reg <= data_next;
  end

  assign data_o   = data_reg;
  assign halted_o = (state_reg == HALTED);
  assign ovf_o    = ovf_reg;

endmodule

// File: tb/tb_ucsbece154b_perf_counters.sv
// Directed bench: a 32-bit and a 4-bit monitor share stimulus; table vectors
// cover event decode, hand sequences cover halt, clear, saturation and async reset.
module tb_ucsbece154b_perf_counters;

  localparam logic [31:0] HALT    = 32'h0001_0064;
  localparam logic [31:0] RUN_PC  = 32'h0000_0100;
  localparam logic [31:0] EXP_ID  = 32'h5045_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i, clear_i;
  logic        validE_i, BranchE_i, JumpE_i, PCSrcE_i, BranchTakenE_i;
  logic [31:0] PCF_i;
  logic [2:0]  sel_i;
  logic [31:0] data_o, data4;
  logic        halted_o, halted4, ovf_o, ovf4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ucsbece154b_perf_counters #(.HALT_PC(HALT), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .clear_i(clear_i),
    .validE_i(validE_i), .BranchE_i(BranchE_i), .JumpE_i(JumpE_i),
    .PCSrcE_i(PCSrcE_i), .BranchTakenE_i(BranchTakenE_i), .PCF_i(PCF_i),
    .sel_i(sel_i), .data_o(data_o), .halted_o(halted_o), .ovf_o(ovf_o)
  );

  ucsbece154b_perf_counters #(.HALT_PC(HALT), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start_i(start_i), .clear_i(clear_i),
    .validE_i(validE_i), .BranchE_i(BranchE_i), .JumpE_i(JumpE_i),
    .PCSrcE_i(PCSrcE_i), .BranchTakenE_i(BranchTakenE_i), .PCF_i(PCF_i),
    .sel_i(sel_i), .data_o(data4), .halted_o(halted4), .ovf_o(ovf4)
  );

  typedef struct {
    logic        valid, br, jmp, pcsrc, bt;
    logic [31:0] exp [6];
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(input bit v, input bit b, input bit j, input bit p, input bit t,
                              input int c, input int btot, input int bm, input int jt,
                              input int jm, input int tk);
    vec_t r;
    r.valid = v; r.br = b; r.jmp = j; r.pcsrc = p; r.bt = t;
    r.exp[0] = 32'(c);  r.exp[1] = 32'(btot); r.exp[2] = 32'(bm);
    r.exp[3] = 32'(jt); r.exp[4] = 32'(jm);   r.exp[5] = 32'(tk);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ev(input bit v, input bit b, input bit j, input bit p, input bit t);
    validE_i = v; BranchE_i = b; JumpE_i = j; PCSrcE_i = p; BranchTakenE_i = t;
  endtask

  task automatic read(input logic [2:0] s, input logic [31:0] exp, input string name);
    sel_i = s;
    tick();
    check($sformatf("%s sel%0d", name, s), data_o, exp);
  endtask

  initial begin
    // counters start at cycles=10 from the warm-up run
    vecs[0]  = mk(1,1,0,1,1, 11,1,0,0,0,1);
    vecs[1]  = mk(1,1,0,0,0, 12,2,0,0,0,1);
    vecs[2]  = mk(1,1,0,1,0, 13,3,1,0,0,2);
    vecs[3]  = mk(1,1,0,0,1, 14,4,2,0,0,2);
    vecs[4]  = mk(1,1,0,1,1, 15,5,2,0,0,3);
    vecs[5]  = mk(1,0,1,1,1, 16,5,2,1,0,3);
    vecs[6]  = mk(1,0,1,1,0, 17,5,2,2,1,3);
    vecs[7]  = mk(0,0,1,1,0, 18,5,2,2,1,3);
    vecs[8]  = mk(1,0,1,1,1, 19,5,2,3,1,3);
    vecs[9]  = mk(1,1,1,0,0, 20,5,2,4,2,3);
    vecs[10] = mk(0,1,0,1,0, 21,5,2,4,2,3);
    vecs[11] = mk(1,0,0,1,0, 22,5,2,4,2,3);

    reset = 1'b0; start_i = 1'b0; clear_i = 1'b0; PCF_i = '0; sel_i = '0;
    set_ev(0,0,0,0,0);

    // Reset state, every select
    repeat (2) tick();
    for (int s = 0; s < 8; s++) read(3'(s), 32'h0, "reset");
    check("reset halted", {31'b0, halted_o}, 32'h0);
    check("reset ovf", {31'b0, ovf_o}, 32'h0);

    // Warm-up: one FSM entry edge then 10 counted cycles
    reset = 1'b1; PCF_i = RUN_PC; start_i = 1'b1; sel_i = 3'd0;
    repeat (11) tick();
    start_i = 1'b0;
    tick();
    check("warmup cycles", data_o, 32'd10);
    $display("warmup done: cycles=%0d", data_o);

    // Table: one active cycle per vector, then read all six counters while paused
    for (int i = 0; i < 12; i++) begin
      set_ev(vecs[i].valid, vecs[i].br, vecs[i].jmp, vecs[i].pcsrc, vecs[i].bt);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      set_ev(0,0,0,0,0);
      for (int s = 0; s < 6; s++) read(3'(s), vecs[i].exp[s], $sformatf("vec%0d", i));
      check($sformatf("vec%0d halted", i), {31'b0, halted_o}, 32'h0);
      $display("vec %0d: v=%0b br=%0b j=%0b src=%0b bt=%0b cycles=%0d",
               i, vecs[i].valid, vecs[i].br, vecs[i].jmp, vecs[i].pcsrc, vecs[i].bt, vecs[i].exp[0]);
    end

    // Halt: the halting cycle and everything after it is not counted
    set_ev(1,1,0,1,1); PCF_i = HALT; start_i = 1'b1;
    tick();
    check("halt halted", {31'b0, halted_o}, 32'h1);
    check("halt halted4", {31'b0, halted4}, 32'h1);
    check("halt ovf4", {31'b0, ovf4}, 32'h1);
    PCF_i = RUN_PC;
    set_ev(1,1,0,0,1); tick();
    set_ev(1,0,1,1,0); tick();
    set_ev(1,1,0,1,1); tick();
    set_ev(0,0,0,0,0); start_i = 1'b0;
    for (int s = 0; s < 6; s++) read(3'(s), vecs[11].exp[s], "halted");
    read(3'd6, 32'h1, "halted status");
    read(3'd7, EXP_ID, "id");
    $display("halt sequence done: halted=%0b", halted_o);

    // Clear wins over start
    clear_i = 1'b1; start_i = 1'b1;
    tick();
    clear_i = 1'b0; start_i = 1'b0;
    check("clear halted", {31'b0, halted_o}, 32'h0);
    check("clear ovf4", {31'b0, ovf4}, 32'h0);
    for (int s = 0; s < 7; s++) read(3'(s), 32'h0, "cleared");
    $display("clear done");

    // Saturation on the 4-bit instance: 20 active cycles
    start_i = 1'b1; sel_i = 3'd0;
    repeat (21) tick();
    start_i = 1'b0;
    tick();
    check("sat cycles32", data_o, 32'd20);
    check("sat cycles4", data4, 32'd15);
    check("sat ovf4", {31'b0, ovf4}, 32'h1);
    check("sat ovf32", {31'b0, ovf_o}, 32'h0);
    sel_i = 3'd6;
    tick();
    check("sat status4", data4, 32'h2);
    check("sat status32", data_o, 32'h0);
    $display("saturation done: cycles4=15");

    // Asynchronous reset mid-run with nonzero counters
    sel_i = 3'd0; start_i = 1'b1;
    repeat (3) tick();
    @(posedge clk);
    #3;
    check("pre-reset data", data_o, 32'd23);
    reset = 1'b0;
    #1;
    check("async data", data_o, 32'h0);
    check("async data4", data4, 32'h0);
    check("async ovf4", {31'b0, ovf4}, 32'h0);
    check("async halted", {31'b0, halted_o}, 32'h0);
    tick();
    reset = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    check("post-reset idle", data_o, 32'h0);
    $display("async reset done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
